// File: rtl/sel_pipe_mux_pkg.sv
// Shared definitions for the select-and-buffer pipeline: FSM state encoding
// and the default data width / channel count.
package sel_pipe_mux_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NUM_IN = 4;

  // Occupancy of the two-entry skid buffer
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/sel_pipe_mux_if.sv
// Handshake bus for sel_pipe_mux: upstream beat (valid/ready/sel/data),
// downstream head beat (valid/ready/data/sel/err) and the flush strobe.
interface sel_pipe_mux_if
  import sel_pipe_mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
);

  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        in_sel;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_err;

  // Environment side: drives beats in, consumes beats out
  modport master (
    output flush, in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_err
  );

  // Block side
  modport slave (
    input  flush, in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_err
  );

endinterface

// File: rtl/sel_pipe_mux_mux_n.sv
// Combinational N:1 channel select. An out-of-range select yields zero data
// and raises err, so every select value has a defined result.
module mux_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data,
  output logic [WIDTH-1:0]        y,
  output logic                    err
);

  // Pick the matching channel; the defaults cover any unmatched select
  always_comb begin
    y   = '0;
    err = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        y   = data[k*WIDTH +: WIDTH];
        err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sel_pipe_mux.sv
// Channel-select stage with a two-entry skid buffer (main, skid). The main
// entry drives the output; the skid entry absorbs one beat when the
// downstream stalls so that in_ready can be a pure register.
module sel_pipe_mux
  import sel_pipe_mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input logic          clk,
  input logic          rst,
  sel_pipe_mux_if.slave bus
);

  state_t           state;
  logic             in_ready_q;
  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic [SEL_W-1:0] main_sel;
  logic             main_err;
  logic [WIDTH-1:0] skid_data;
  logic [SEL_W-1:0] skid_sel;
  logic             skid_err;

  logic [WIDTH-1:0] mux_data;
  logic             mux_err;
  logic             accept;
  logic             drain;

  mux_n #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .sel  (bus.in_sel),
    .data (bus.in_data),
    .y    (mux_data),
    .err  (mux_err)
  );

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = main_valid & bus.out_ready;

  // Buffer FSM: occupancy, registered handshake outputs and both entries.
  // Flush outranks any accept or drain in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_valid <= 1'b0;
      main_data  <= '0;
      main_sel   <= '0;
      main_err   <= 1'b0;
      skid_data  <= '0;
      skid_sel   <= '0;
      skid_err   <= 1'b0;
    end else if (bus.flush) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_data  <= mux_data;
            main_sel   <= bus.in_sel;
            main_err   <= mux_err;
            main_valid <= 1'b1;
            state      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_data <= mux_data;
            main_sel  <= bus.in_sel;
            main_err  <= mux_err;
          end else if (accept) begin
            skid_data  <= mux_data;
            skid_sel   <= bus.in_sel;
            skid_err   <= mux_err;
            in_ready_q <= 1'b0;
            state      <= ST_FULL;
          end else if (drain) begin
            main_valid <= 1'b0;
            state      <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a drain can happen
          if (drain) begin
            main_data  <= skid_data;
            main_sel   <= skid_sel;
            main_err   <= skid_err;
            in_ready_q <= 1'b1;
            state      <= ST_ONE;
          end
        end
        default: begin
          state      <= ST_EMPTY;
          in_ready_q <= 1'b1;
          main_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_data;
  assign bus.out_sel   = main_sel;
  assign bus.out_err   = main_err;

endmodule

// File: tb/tb_sel_pipe_mux.sv
// Directed bench for sel_pipe_mux: a 4-channel instance for select,
// backpressure, flush, reset and throughput, and a 3-channel instance for
// out-of-range selects.
module tb_sel_pipe_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  sel_pipe_mux_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) ba ();
  sel_pipe_mux_if #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) bb ();

  sel_pipe_mux #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ba.slave)
  );

  sel_pipe_mux #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bb.slave)
  );

  logic [31:0] chan_val [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int       sel;
    int       exp_q[$];
    int       head;

    ba.flush     = 1'b0;
    ba.in_valid  = 1'b0;
    ba.in_sel    = '0;
    ba.in_data   = {32'h44, 32'h33, 32'h22, 32'h11};
    ba.out_ready = 1'b0;
    bb.flush     = 1'b0;
    bb.in_valid  = 1'b0;
    bb.in_sel    = '0;
    bb.in_data   = {32'h33, 32'h22, 32'h11};
    bb.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", ba.out_valid, 0);
    chk("rst_in_ready",  ba.in_ready,  1);
    chk("rst_out_data",  ba.out_data,  0);
    chk("rst_out_sel",   ba.out_sel,   0);
    chk("rst_out_err",   ba.out_err,   0);
    rst = 1'b0;

    // Basic select: channel 2
    @(negedge clk);
    ba.in_valid = 1'b1; ba.in_sel = 2'd2; ba.out_ready = 1'b1;
    @(negedge clk);
    ba.in_valid = 1'b0;
    chk("sel_valid", ba.out_valid, 1);
    chk("sel_data",  ba.out_data,  32'h33);
    chk("sel_sel",   ba.out_sel,   2);
    chk("sel_err",   ba.out_err,   0);
    @(negedge clk);
    chk("sel_drained", ba.out_valid, 0);

    // Backpressure: two beats fill the buffer
    ba.out_ready = 1'b0;
    ba.in_valid = 1'b1; ba.in_sel = 2'd0;
    @(negedge clk);
    chk("bp_one_ready", ba.in_ready, 1);
    chk("bp_one_data",  ba.out_data, 32'h11);
    ba.in_sel = 2'd1;
    @(negedge clk);
    chk("bp_full_ready", ba.in_ready,  0);
    chk("bp_full_valid", ba.out_valid, 1);
    chk("bp_full_data",  ba.out_data,  32'h11);
    ba.in_sel = 2'd3;  // offered while full, must not be taken
    @(negedge clk);
    chk("bp_hold_data",  ba.out_data, 32'h11);
    chk("bp_hold_sel",   ba.out_sel,  0);
    chk("bp_hold_ready", ba.in_ready, 0);
    ba.in_valid = 1'b0; ba.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_second_data",  ba.out_data,  32'h22);
    chk("bp_second_sel",   ba.out_sel,   1);
    chk("bp_second_ready", ba.in_ready,  1);
    @(negedge clk);
    chk("bp_empty", ba.out_valid, 0);

    // Out-of-range select on the 3-channel instance, then an in-range one
    bb.out_ready = 1'b1;
    bb.in_valid = 1'b1; bb.in_sel = 2'd3;
    @(negedge clk);
    chk("oor_valid", bb.out_valid, 1);
    chk("oor_data",  bb.out_data,  0);
    chk("oor_err",   bb.out_err,   1);
    chk("oor_sel",   bb.out_sel,   3);
    bb.in_sel = 2'd1;
    @(negedge clk);
    bb.in_valid = 1'b0;
    chk("inr_data", bb.out_data, 32'h22);
    chk("inr_err",  bb.out_err,  0);
    @(negedge clk);
    chk("b_empty", bb.out_valid, 0);

    // Flush from FULL with a beat offered
    ba.out_ready = 1'b0;
    ba.in_valid = 1'b1; ba.in_sel = 2'd2;
    @(negedge clk);
    ba.in_sel = 2'd3;
    @(negedge clk);
    chk("fl_full", ba.in_ready, 0);
    ba.flush = 1'b1; ba.in_sel = 2'd0;
    @(negedge clk);
    ba.flush = 1'b0; ba.in_valid = 1'b0;
    chk("fl_valid", ba.out_valid, 0);
    chk("fl_ready", ba.in_ready,  1);
    ba.out_ready = 1'b1;
    @(negedge clk);
    chk("fl_nothing", ba.out_valid, 0);

    // Reset between edges while holding one beat
    ba.out_ready = 1'b0;
    ba.in_valid = 1'b1; ba.in_sel = 2'd3;
    @(negedge clk);
    ba.in_valid = 1'b0;
    chk("mr_before_valid", ba.out_valid, 1);
    chk("mr_before_data",  ba.out_data,  32'h44);
    #2 rst = 1'b1;
    #1;
    chk("mr_valid", ba.out_valid, 0);
    chk("mr_data",  ba.out_data,  0);
    chk("mr_sel",   ba.out_sel,   0);
    chk("mr_ready", ba.in_ready,  1);
    #1 rst = 1'b0;
    ba.in_valid = 1'b1; ba.in_sel = 2'd1; ba.out_ready = 1'b1;
    @(negedge clk);
    ba.in_valid = 1'b0;
    chk("mr_first_valid", ba.out_valid, 1);
    chk("mr_first_data",  ba.out_data,  32'h22);

    // Throughput: 100 back-to-back beats, one output per cycle, in order
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);
      if (i > 0) begin
        head = exp_q.pop_front();
        chk("tp_valid", ba.out_valid, 1);
        chk("tp_data",  ba.out_data,  chan_val[head]);
        chk("tp_sel",   ba.out_sel,   head);
      end
      chk("tp_ready", ba.in_ready, 1);
      if (i < 100) begin
        sel = int'($urandom_range(0, 3));
        exp_q.push_back(sel);
        ba.in_valid = 1'b1;
        ba.in_sel   = 2'(sel);
      end else begin
        ba.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("tp_done", ba.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
